// File: rtl/interlaken_pkg.sv
// Interlaken lane constants, header codes and framer state encoding.
// Shared by the TX lane framer and its CRC32-C helper.
package interlaken_pkg;

  localparam logic [63:0] SYNC_WORD  = 64'h78f678f678f678f6;
  localparam logic [63:0] STATE_WORD = 64'h2800000000000000;
  localparam logic [63:0] SKIP_WORD  = 64'h1e1e1e1e1e1e1e1e;
  localparam logic [5:0]  DIAG_TYPE  = 6'b011001;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam logic [31:0] CRC32C_POLY = 32'h1EDC6F41;

  typedef enum logic [2:0] {
    SYNC,
    SCRAM,
    SKIP,
    PAYLOAD,
    DIAG
  } frame_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/metaframe_framer_if.sv
// Lane word stream: 64b word plus 2b 64b/67b header.
// Master drives word/valid, slave drives ready.
interface metaframe_framer_if;
  logic [63:0] data;
  logic [1:0]  header;
  logic        valid;
  logic        ready;

  modport master (
    output data,
    output header,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  header,
    input  valid,
    output ready
  );
endinterface

// File: rtl/metaframe_framer_crc32c_64.sv
// Combinational CRC32-C (reflected) advance over one 64b word.
// Bit 0 of the word is shifted in first.
module crc32c_64
  import interlaken_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = reflect32(CRC32C_POLY);

  // serial LFSR unrolled across all 64 data bits
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 64; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) c = (c >> 1) ^ POLY_R;
      else                          c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/metaframe_framer.sv
// Interlaken TX lane framer: Sync/State/Skip/payload/Diag metaframes.
// Optional CRC32-C in the Diag word via FRAMER_CRC32_EN.
module metaframe_framer
  import interlaken_pkg::*;
#(
  parameter int          TX_DATA_WIDTH = 64,
  parameter int          METAFRAME_LEN = 2048,
  parameter logic [63:0] SYNC_WORD     = interlaken_pkg::SYNC_WORD,
  parameter logic [63:0] STATE_WORD    = interlaken_pkg::STATE_WORD,
  parameter logic [63:0] SKIP_WORD     = interlaken_pkg::SKIP_WORD,
  parameter logic [5:0]  DIAG_TYPE     = interlaken_pkg::DIAG_TYPE
) (
  input  logic               USER_CLK,
  input  logic               SYSTEM_RESET_N,
  metaframe_framer_if.slave  in_lane,
  metaframe_framer_if.master out_lane,
  input  logic [1:0]         LANE_STATUS,
  input  logic               PASSTHROUGH,
  output logic               META_START
);

  localparam int CW = $clog2(METAFRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(METAFRAME_LEN - 5);

  if (METAFRAME_LEN < 5) begin : g_len_chk
    $error("METAFRAME_LEN must be at least 5");
  end
  if (TX_DATA_WIDTH != 64) begin : g_width_chk
    $error("only TX_DATA_WIDTH 64 is supported");
  end

  logic [1:0]   rst_sync_q;
  logic         rst_core_n;
  frame_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]  data_q, data_d;
  logic [1:0]   hdr_q, hdr_d;
  logic         vld_q, vld_d;
  logic         meta_q, meta_d;
  logic         rdy;
  logic         slot;
  logic [31:0]  diag_hi;
  logic [63:0]  frame_word;
  logic [1:0]   frame_hdr;
  logic [31:0]  crc_field;

  assign slot    = out_lane.ready;
  assign diag_hi = {DIAG_TYPE, 24'h0, LANE_STATUS};

  // reset: assert immediately, release two clocks later
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_core_n = rst_sync_q[1];

  // word the current framing slot carries (Diag CRC field zeroed)
  always_comb begin
    frame_word = SKIP_WORD;
    frame_hdr  = HDR_CTRL;
    unique case (state_q)
      SYNC:    frame_word = SYNC_WORD;
      SCRAM:   frame_word = STATE_WORD;
      SKIP:    frame_word = SKIP_WORD;
      PAYLOAD: begin
        if (in_lane.valid) begin
          frame_word = in_lane.data;
          frame_hdr  = in_lane.header;
        end
      end
      DIAG:    frame_word = {diag_hi, 32'h0};
      default: frame_word = SKIP_WORD;
    endcase
  end

`ifdef FRAMER_CRC32_EN
  logic [31:0] crc_q, crc_next;

  crc32c_64 u_crc (
    .crc_in  (crc_q),
    .data    (frame_word),
    .crc_out (crc_next)
  );

  assign crc_field = ~crc_next;

  // running CRC, reloaded after Diag and in passthrough
  always_ff @(posedge USER_CLK or negedge rst_core_n) begin
    if (!rst_core_n) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (slot) begin
      if (PASSTHROUGH || state_q == DIAG) crc_q <= 32'hFFFFFFFF;
      else                                crc_q <= crc_next;
    end
  end
`else
  assign crc_field = 32'h0;
`endif

  // next state, counter and output word for this slot
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    hdr_d   = hdr_q;
    vld_d   = slot;
    meta_d  = 1'b0;
    rdy     = 1'b0;
    if (slot) begin
      if (PASSTHROUGH) begin
        rdy     = 1'b1;
        data_d  = in_lane.data;
        hdr_d   = in_lane.header;
        state_d = SYNC;
        cnt_d   = '0;
      end else begin
        data_d = (state_q == DIAG) ? {diag_hi, crc_field} : frame_word;
        hdr_d  = frame_hdr;
        meta_d = (state_q == SYNC);
        unique case (state_q)
          SYNC:  state_d = SCRAM;
          SCRAM: state_d = SKIP;
          SKIP: begin
            state_d = PAYLOAD;
            cnt_d   = '0;
          end
          PAYLOAD: begin
            rdy = 1'b1;
            if (cnt_q == LAST) state_d = DIAG;
            else               cnt_d   = cnt_q + 1'b1;
          end
          DIAG:    state_d = SYNC;
          default: state_d = SYNC;
        endcase
      end
    end
  end

  // state and registered output stage
  always_ff @(posedge USER_CLK or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      data_q  <= '0;
      hdr_q   <= 2'b00;
      vld_q   <= 1'b0;
      meta_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      vld_q   <= vld_d;
      meta_q  <= meta_d;
    end
  end

  assign in_lane.ready   = rdy & rst_core_n;
  assign out_lane.data   = data_q;
  assign out_lane.header = hdr_q;
  assign out_lane.valid  = vld_q;
  assign META_START      = meta_q;

endmodule
